addr_pattern_gen: RTL and testbench
===================================

Name: addr_pattern_gen

Overview:
Parametrised successor to the random-only DRAM test address generator. It provides independent write and read address streams with three selectable patterns: sequential, strided and xorshift128+ random. Addresses are confined to a power-of-two window above a programmable base. Each run stops after a programmed operation count, and the read stream replays the write stream exactly, so the memory checker can verify data in write order.

Parameters:
ADDR_WIDTH, 27, byte address width; must satisfy ALIGN_BITS < ADDR_WIDTH <= 64+ALIGN_BITS
ALIGN_BITS, 3, low address bits forced to zero (access granularity 2^ALIGN_BITS bytes)
COUNT_WIDTH, 32, width of the operation counters
SEED, 20200826, random generator seed; must be nonzero

Ports:
clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_start  in  1  one-cycle pulse: latch configuration, reseed, clear counters, begin run
i_mode  in  2  0 sequential, 1 strided, 2 random, 3 reserved (treated as sequential)
i_base  in  ADDR_WIDTH  window base byte address; low ALIGN_BITS are ignored (treated as zero)
i_span_log2  in  8  log2 of window size in aligned units
i_stride  in  ADDR_WIDTH-ALIGN_BITS  unit stride for mode 1
i_count  in  COUNT_WIDTH  operations per channel for this run
i_wen  in  1  write issued this cycle; advance write stream
i_ren  in  1  read issued this cycle; advance read stream
o_waddr  out  ADDR_WIDTH  current write address
o_raddr  out  ADDR_WIDTH  current read address
o_wdone  out  1  write channel has completed i_count advances
o_rdone  out  1  read channel has completed i_count advances
o_busy  out  1  either channel in RUN

Behaviour:
- U = ADDR_WIDTH-ALIGN_BITS.
- Configuration registers (mode, base, span, stride, count) are latched only on i_start. Inputs may change freely mid-run.
- Effective span: S = min(i_span_log2, U). Mask M = 2^S-1. S=0 gives a single-unit window.
- Each channel is an identical copy and holds: state, U-bit unit index, COUNT_WIDTH-bit counter, and 128-bit xorshift state (s0,s1).
- Seeding: s0 = SEED, s1 = ~SEED, both 64 bits.
- Random value R = s0 + s1, mod 2^64.
- Xorshift step:
  - t = s0 ^ (s0<<23)
  - s0' = s1
  - s1' = t ^ s1 ^ (t>>17) ^ (s1>>26)
- Unit offset:
  - modes 0/1/3: index & M
  - mode 2: R[U-1:0] & M
- Address = ({base[ADDR_WIDTH-1:ALIGN_BITS]} + offset) << ALIGN_BITS, truncated mod 2^ADDR_WIDTH (wraps past top of memory).
- Address outputs are a combinational function of registered state only. They are valid for the whole cycle and reflect the address of the next operation.
- Per-channel FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on i_start.
  - RUN, advance strobe high:
    - index += 1 (modes 0/3) or += stride (mode 1), mod 2^U
    - xorshift stepped in mode 2 only
    - counter += 1
    - if the new counter == count, go to DONE
  - DONE, and RUN without a strobe: all channel state holds.
  - Any state -> RUN on i_start, with index 0, counter 0, reseed.
- i_start with i_count == 0: channel goes to DONE the cycle after start instead of RUN; o_wdone/o_rdone = 1, o_busy = 0.
- i_wen/i_ren are ignored in IDLE and DONE, and in the cycle i_start is high (start wins).
- o_wdone = (write state == DONE); o_rdone = (read state == DONE). Both are registered-state decodes with zero latency after the final advance edge.
- Window wrap: the index keeps counting and only the masked offset wraps. With a stride and mask that share a common factor, the generator revisits a subset of units; this is legal.
- Asynchronous reset, effective immediately regardless of clk:
  - both channels IDLE, index 0, counter 0, reseeded
  - configuration registers zero
  - o_waddr = o_raddr = 0, o_wdone = o_rdone = o_busy = 0
- Reset mid-run aborts the run. No run resumes without a new i_start.
- Write and read channels are fully independent. Simultaneous i_wen and i_ren each advance their own channel in the same cycle.

Test Plan:
- Reset, then mode 0, base 0x100, span_log2 2, count 6, one i_wen per cycle -> o_waddr 0x100,0x108,0x110,0x118,0x100,0x108. o_wdone rises after the 6th advance; o_busy stays 1 until reads also finish.
- Mode 1, base 0, span_log2 3, stride 3, count 5 -> o_waddr 0x00,0x18,0x30,0x08,0x20. Extra i_wen after done leaves o_waddr at 0x38 (index 15 & 7 = 7) unchanged.
- Mode 2, span_log2 24, count 1000, random bursty i_wen, then i_ren delayed 50 cycles -> the i-th o_raddr equals the i-th o_waddr for every i, and the first address matches the golden model, (SEED + ~SEED)[23:0] << 3.
- i_start with i_count 0 -> o_wdone = o_rdone = 1 and o_busy = 0 one cycle later. Strobes have no effect.
- Mid-run i_start asserted together with i_wen -> the strobe is ignored, the sequence restarts from the first address, and the counter restarts at 0.
- i_rst asserted asynchronously mid-cycle during RUN -> all outputs 0 before the next clk edge. Strobes after reset do not move the addresses.

Source files
------------

// File: rtl/addr_pattern_gen.sv
// rtl/addr_pattern_gen.sv - sequential/strided/xorshift128+ DRAM test address generator
//
// addr_pattern_chan: one address stream (IDLE/RUN/DONE FSM, unit index,
//   op counter, xorshift128+ state). o_addr is a decode of registered state.
// addr_pattern_gen: latches the run configuration on i_start and drives an
//   identical write channel and read channel, so reads replay writes exactly.
//   clk, i_rst (async, active-high), i_start, i_mode, i_base, i_span_log2,
//   i_stride, i_count, i_wen, i_ren -> o_waddr, o_raddr, o_wdone, o_rdone, o_busy

module addr_pattern_chan #(
    parameter int          ADDR_WIDTH  = 27,
    parameter int          ALIGN_BITS  = 3,
    parameter int          COUNT_WIDTH = 32,
    parameter logic [63:0] SEED        = 64'd20200826
) (
    input  logic                                clk,
    input  logic                                i_rst,
    input  logic                                i_start,
    input  logic                                i_count_zero,
    input  logic                                i_adv,
    input  logic [1:0]                          i_mode,
    input  logic [ADDR_WIDTH-ALIGN_BITS-1:0]    i_base_u,
    input  logic [ADDR_WIDTH-ALIGN_BITS-1:0]    i_stride,
    input  logic [ADDR_WIDTH-ALIGN_BITS-1:0]    i_mask,
    input  logic [COUNT_WIDTH-1:0]              i_count,
    output logic [ADDR_WIDTH-1:0]               o_addr,
    output logic                                o_done,
    output logic                                o_run
);
    localparam int U = ADDR_WIDTH - ALIGN_BITS;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t                 state_q, state_d;
    logic [U-1:0]           idx_q, idx_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [63:0]            s0_q, s0_d, s1_q, s1_d;
    logic [63:0]            t, rnd;
    logic [U-1:0]           offset;
    logic                   adv_en;

    // State register
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            s0_q    <= SEED;
            s1_q    <= ~SEED;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
        end
    end

    // Next state; start overrides any strobe in the same cycle
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        t       = s0_q ^ (s0_q << 23);
        if (i_start) begin
            state_d = i_count_zero ? DONE : RUN;
            idx_d   = '0;
            cnt_d   = '0;
            s0_d    = SEED;
            s1_d    = ~SEED;
        end else if (adv_en) begin
            idx_d = (i_mode == 2'd1) ? idx_q + i_stride : idx_q + 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (i_mode == 2'd2) begin
                s0_d = s1_q;
                s1_d = t ^ s1_q ^ (t >> 17) ^ (s1_q >> 26);
            end
            if (cnt_d == i_count) begin
                state_d = DONE;
            end
        end
    end

    // Outputs: pure decode of registered state
    always_comb begin
        adv_en = (state_q == RUN) && i_adv;
        o_done = (state_q == DONE);
        o_run  = (state_q == RUN);
        rnd    = s0_q + s1_q;
        offset = ((i_mode == 2'd2) ? U'(rnd) : idx_q) & i_mask;
        o_addr = {i_base_u + offset, {ALIGN_BITS{1'b0}}};
    end
endmodule

module addr_pattern_gen #(
    parameter int          ADDR_WIDTH  = 27,
    parameter int          ALIGN_BITS  = 3,
    parameter int          COUNT_WIDTH = 32,
    parameter logic [63:0] SEED        = 64'd20200826
) (
    input  logic                                clk,
    input  logic                                i_rst,
    input  logic                                i_start,
    input  logic [1:0]                          i_mode,
    input  logic [ADDR_WIDTH-1:0]               i_base,
    input  logic [7:0]                          i_span_log2,
    input  logic [ADDR_WIDTH-ALIGN_BITS-1:0]    i_stride,
    input  logic [COUNT_WIDTH-1:0]              i_count,
    input  logic                                i_wen,
    input  logic                                i_ren,
    output logic [ADDR_WIDTH-1:0]               o_waddr,
    output logic [ADDR_WIDTH-1:0]               o_raddr,
    output logic                                o_wdone,
    output logic                                o_rdone,
    output logic                                o_busy
);
    localparam int U = ADDR_WIDTH - ALIGN_BITS;

    logic [1:0]             mode_q;
    logic [U-1:0]           base_q, stride_q, mask;
    logic [7:0]             span_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   count_zero, wrun, rrun;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            mode_q   <= '0;
            base_q   <= '0;
            span_q   <= '0;
            stride_q <= '0;
            count_q  <= '0;
        end else if (i_start) begin
            mode_q   <= i_mode;
            base_q   <= U'(i_base >> ALIGN_BITS);
            span_q   <= i_span_log2;
            stride_q <= i_stride;
            count_q  <= i_count;
        end
    end

    // Bit i of the mask is set for i < min(span, U); the loop bound supplies the min
    always_comb begin
        mask = '0;
        for (int i = 0; i < U; i++) begin
            mask[i] = (int'(span_q) > i);
        end
    end

    assign count_zero = (i_count == '0);
    assign o_busy     = wrun | rrun;

    addr_pattern_chan #(
        .ADDR_WIDTH(ADDR_WIDTH), .ALIGN_BITS(ALIGN_BITS),
        .COUNT_WIDTH(COUNT_WIDTH), .SEED(SEED)
    ) u_wchan (
        .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_count_zero(count_zero),
        .i_adv(i_wen), .i_mode(mode_q), .i_base_u(base_q), .i_stride(stride_q),
        .i_mask(mask), .i_count(count_q),
        .o_addr(o_waddr), .o_done(o_wdone), .o_run(wrun)
    );

    addr_pattern_chan #(
        .ADDR_WIDTH(ADDR_WIDTH), .ALIGN_BITS(ALIGN_BITS),
        .COUNT_WIDTH(COUNT_WIDTH), .SEED(SEED)
    ) u_rchan (
        .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_count_zero(count_zero),
        .i_adv(i_ren), .i_mode(mode_q), .i_base_u(base_q), .i_stride(stride_q),
        .i_mask(mask), .i_count(count_q),
        .o_addr(o_raddr), .o_done(o_rdone), .o_run(rrun)
    );
endmodule

// File: tb/tb_addr_pattern_gen.sv
// tb/tb_addr_pattern_gen.sv - directed self-checking bench for addr_pattern_gen

module tb_addr_pattern_gen;
    logic        clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_start = 1'b0;
    logic [1:0]  i_mode = '0;
    logic [26:0] i_base = '0;
    logic [7:0]  i_span_log2 = '0;
    logic [23:0] i_stride = '0;
    logic [31:0] i_count = '0;
    logic        i_wen = 1'b0;
    logic        i_ren = 1'b0;
    logic [26:0] o_waddr, o_raddr;
    logic        o_wdone, o_rdone, o_busy;

    int n_assert = 0;
    int n_fail   = 0;

    addr_pattern_gen dut (
        .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode),
        .i_base(i_base), .i_span_log2(i_span_log2), .i_stride(i_stride),
        .i_count(i_count), .i_wen(i_wen), .i_ren(i_ren),
        .o_waddr(o_waddr), .o_raddr(o_raddr), .o_wdone(o_wdone),
        .o_rdone(o_rdone), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [1:0] mode, input logic [26:0] base,
                             input logic [7:0] span, input logic [23:0] stride,
                             input logic [31:0] count);
        i_mode = mode; i_base = base; i_span_log2 = span;
        i_stride = stride; i_count = count; i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    logic [26:0] exp1 [6] = '{27'h100, 27'h108, 27'h110, 27'h118, 27'h100, 27'h108};
    logic [26:0] exp2 [5] = '{27'h00, 27'h18, 27'h30, 27'h08, 27'h20};
    logic [26:0] wq [$];
    logic [63:0] s0, s1, r, t;
    int wn, rn;

    initial begin
        // Reset
        #1 i_rst = 1'b1;
        #1;
        check("rst_waddr", 64'(o_waddr), 64'h0);
        check("rst_raddr", 64'(o_raddr), 64'h0);
        check("rst_flags", 64'({o_wdone, o_rdone, o_busy}), 64'h0);
        tick();
        i_rst = 1'b0;
        tick();

        // Sequential with window wrap
        start_run(2'd0, 27'h100, 8'd2, 24'd0, 32'd6);
        check("seq_busy", 64'(o_busy), 64'h1);
        for (int k = 0; k < 6; k++) begin
            check("seq_waddr", 64'(o_waddr), 64'(exp1[k]));
            check("seq_wdone_early", 64'(o_wdone), 64'h0);
            i_wen = 1'b1;
            tick();
            i_wen = 1'b0;
        end
        check("seq_wdone", 64'(o_wdone), 64'h1);
        check("seq_busy_reads_pending", 64'(o_busy), 64'h1);
        for (int k = 0; k < 6; k++) begin
            check("seq_raddr", 64'(o_raddr), 64'(exp1[k]));
            i_ren = 1'b1;
            tick();
            i_ren = 1'b0;
        end
        check("seq_rdone", 64'(o_rdone), 64'h1);
        check("seq_busy_end", 64'(o_busy), 64'h0);

        // Strided
        start_run(2'd1, 27'h0, 8'd3, 24'd3, 32'd5);
        for (int k = 0; k < 5; k++) begin
            check("stride_waddr", 64'(o_waddr), 64'(exp2[k]));
            i_wen = 1'b1;
            tick();
        end
        tick();
        tick();
        i_wen = 1'b0;
        check("stride_hold_waddr", 64'(o_waddr), 64'h38);
        check("stride_wdone", 64'(o_wdone), 64'h1);

        // Random: reads replay writes, writes follow the xorshift128+ model
        start_run(2'd2, 27'h0, 8'd24, 24'd0, 32'd1000);
        check("rand_first", 64'(o_waddr), 64'h7FFFFF8);
        s0 = 64'd20200826;
        s1 = ~s0;
        wn = 0;
        rn = 0;
        for (int c = 0; c < 6000 && !(o_wdone && o_rdone); c++) begin
            i_wen = !o_wdone && ($urandom_range(0, 3) != 0);
            i_ren = (c >= 50) && !o_rdone && (rn < wn) && ($urandom_range(0, 3) != 0);
            if (i_wen) begin
                r = s0 + s1;
                check("rand_waddr", 64'(o_waddr), 64'({r[23:0], 3'b000}));
                wq.push_back(o_waddr);
                t = s0 ^ (s0 << 23);
                s0 = s1;
                s1 = t ^ s1 ^ (t >> 17) ^ (s1 >> 26);
                wn++;
            end
            if (i_ren) begin
                check("rand_raddr", 64'(o_raddr), 64'(wq[rn]));
                rn++;
            end
            tick();
        end
        i_wen = 1'b0;
        i_ren = 1'b0;
        check("rand_wdone", 64'(o_wdone), 64'h1);
        check("rand_rdone", 64'(o_rdone), 64'h1);
        check("rand_wcount", 64'(wn), 64'd1000);
        check("rand_rcount", 64'(rn), 64'd1000);

        // Zero count goes straight to DONE
        start_run(2'd0, 27'h200, 8'd4, 24'd0, 32'd0);
        check("zero_flags", 64'({o_wdone, o_rdone, o_busy}), 64'b110);
        i_wen = 1'b1;
        i_ren = 1'b1;
        tick();
        i_wen = 1'b0;
        i_ren = 1'b0;
        check("zero_waddr", 64'(o_waddr), 64'h200);
        check("zero_raddr", 64'(o_raddr), 64'h200);

        // Start together with a strobe restarts the sequence and counter
        start_run(2'd0, 27'h0, 8'd4, 24'd0, 32'd10);
        i_wen = 1'b1;
        tick();
        tick();
        tick();
        check("restart_pre", 64'(o_waddr), 64'h18);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_wen = 1'b0;
        check("restart_addr", 64'(o_waddr), 64'h0);
        for (int k = 0; k < 10; k++) begin
            check("restart_wdone_early", 64'(o_wdone), 64'h0);
            i_wen = 1'b1;
            tick();
            i_wen = 1'b0;
        end
        check("restart_wdone", 64'(o_wdone), 64'h1);
        check("restart_waddr_end", 64'(o_waddr), 64'h50);

        // Asynchronous reset mid-run
        start_run(2'd0, 27'h40, 8'd4, 24'd0, 32'd8);
        i_wen = 1'b1;
        tick();
        tick();
        i_wen = 1'b0;
        check("arst_pre", 64'(o_waddr), 64'h50);
        #3 i_rst = 1'b1;
        #1;
        check("arst_waddr", 64'(o_waddr), 64'h0);
        check("arst_raddr", 64'(o_raddr), 64'h0);
        check("arst_flags", 64'({o_wdone, o_rdone, o_busy}), 64'h0);
        tick();
        i_rst = 1'b0;
        i_wen = 1'b1;
        i_ren = 1'b1;
        tick();
        tick();
        i_wen = 1'b0;
        i_ren = 1'b0;
        check("post_rst_waddr", 64'(o_waddr), 64'h0);
        check("post_rst_raddr", 64'(o_raddr), 64'h0);
        check("post_rst_busy", 64'(o_busy), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
